// File: rtl/rl_queue_lvl.sv
// rl_queue_lvl: fall-through queue with registered level/status flags.
// Optional sticky overflow/underflow flags: define RL_QUEUE_LVL_ERR_EN.
module rl_queue_lvl #(
    parameter int DEPTH      = 4,
    parameter int DBITS      = 32,
    parameter int AFULL_LVL  = DEPTH - 1,
    parameter int AEMPTY_LVL = 1
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       clr_i,
    input  logic                       ena_i,
    input  logic                       we_i,
    input  logic [DBITS-1:0]           d_i,
    input  logic                       re_i,
    output logic [DBITS-1:0]           q_o,
    output logic                       empty_o,
    output logic                       full_o,
    output logic                       almost_empty_o,
    output logic                       almost_full_o,
    output logic [$clog2(DEPTH+1)-1:0] level_o,
    input  logic                       err_clr_i,
    output logic                       overflow_o,
    output logic                       underflow_o
);

    localparam int LW = $clog2(DEPTH + 1);

    logic [DBITS-1:0] r_mem [DEPTH];
    logic [LW-1:0]    r_lvl;
    logic             r_empty;
    logic             r_full;
    logic             r_aempty;
    logic             r_afull;

    logic [DBITS-1:0] w_mem_nxt [DEPTH];
    logic [LW-1:0]    w_lvl_nxt;
    logic [LW-1:0]    w_widx;
    logic             w_rd;
    logic             w_wr;

    // A write while full is only accepted when a read frees the tail slot.
    assign w_rd = ena_i & re_i & ~r_empty;
    assign w_wr = ena_i & we_i & (~r_full | re_i);

    assign w_widx    = w_rd ? r_lvl - LW'(1) : r_lvl;
    assign w_lvl_nxt = r_lvl + LW'(w_wr) - LW'(w_rd);

    // Next contents: shift toward the head on a read, then place new data.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_mem_nxt[i] = r_mem[i];
        end
        if (w_rd) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                w_mem_nxt[i] = r_mem[i+1];
            end
            w_mem_nxt[DEPTH-1] = '0;
        end
        if (w_wr) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (LW'(i) == w_widx) begin
                    w_mem_nxt[i] = d_i;
                end
            end
        end
    end

    // Storage, level and status flags; status is computed from next level.
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            r_mem    <= '{default: '0};
            r_lvl    <= '0;
            r_empty  <= 1'b1;
            r_full   <= 1'b0;
            r_aempty <= 1'b1;
            r_afull  <= 1'b0;
        end else if (ena_i) begin
            r_mem    <= w_mem_nxt;
            r_lvl    <= w_lvl_nxt;
            r_empty  <= (w_lvl_nxt == '0);
            r_full   <= (w_lvl_nxt == LW'(DEPTH));
            r_aempty <= (w_lvl_nxt <= LW'(AEMPTY_LVL));
            r_afull  <= (w_lvl_nxt >= LW'(AFULL_LVL));
        end
    end

    assign q_o            = r_mem[0];
    assign level_o        = r_lvl;
    assign empty_o        = r_empty;
    assign full_o         = r_full;
    assign almost_empty_o = r_aempty;
    assign almost_full_o  = r_afull;

`ifdef RL_QUEUE_LVL_ERR_EN
    logic r_ovf;
    logic r_unf;
    logic w_ovf_set;
    logic w_unf_set;

    assign w_ovf_set = ena_i & we_i & r_full & ~re_i;
    assign w_unf_set = ena_i & re_i & r_empty;

    // Sticky error flags; a new event outranks err_clr_i in the same cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end else if (err_clr_i) begin
                r_ovf <= 1'b0;
            end
            if (w_unf_set) begin
                r_unf <= 1'b1;
            end else if (err_clr_i) begin
                r_unf <= 1'b0;
            end
        end
    end

    assign overflow_o  = r_ovf;
    assign underflow_o = r_unf;
`else
    // Flags tied low; err_clr_i has no effect in this build.
    assign overflow_o  = err_clr_i & 1'b0;
    assign underflow_o = err_clr_i & 1'b0;
`endif

endmodule

// File: tb/tb_rl_queue_lvl.sv
// tb_rl_queue_lvl: directed plus random checks against a queue model.
module tb_rl_queue_lvl;

    logic       clk;
    logic       rst, clr, ena, we, re, eclr;
    logic [7:0] d;
    logic [7:0] q;
    logic       empty, full, aempty, afull, ovf, unf;
    logic [2:0] lvl;

    int nvec = 0;
    int nerr = 0;

    logic [7:0] mq [$];
    bit         m_ovf = 0;
    bit         m_unf = 0;

    rl_queue_lvl #(
        .DEPTH(4), .DBITS(8), .AFULL_LVL(3), .AEMPTY_LVL(1)
    ) dut (
        .clk_i(clk), .rst_i(rst), .clr_i(clr), .ena_i(ena),
        .we_i(we), .d_i(d), .re_i(re), .q_o(q),
        .empty_o(empty), .full_o(full),
        .almost_empty_o(aempty), .almost_full_o(afull),
        .level_o(lvl), .err_clr_i(eclr),
        .overflow_o(ovf), .underflow_o(unf)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic [7:0] got,
                        input logic [7:0] exp);
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic check(input string tag);
        int n;
        n = mq.size();
        nvec++;
        chk1({tag, ".q"}, q, n > 0 ? mq[0] : 8'h00);
        chk1({tag, ".lvl"}, {5'b0, lvl}, 8'(n));
        chk1({tag, ".empty"}, {7'b0, empty}, {7'b0, n == 0});
        chk1({tag, ".full"}, {7'b0, full}, {7'b0, n == 4});
        chk1({tag, ".aempty"}, {7'b0, aempty}, {7'b0, n <= 1});
        chk1({tag, ".afull"}, {7'b0, afull}, {7'b0, n >= 3});
        chk1({tag, ".ovf"}, {7'b0, ovf}, {7'b0, m_ovf});
        chk1({tag, ".unf"}, {7'b0, unf}, {7'b0, m_unf});
    endtask

    task automatic model(input bit r, c, e, w, p, input logic [7:0] dv,
                         input bit ec);
        bit isfull, isempty, so, su;
        if (r || c) begin
            mq.delete();
            m_ovf = 0;
            m_unf = 0;
        end else begin
            isfull  = mq.size() == 4;
            isempty = mq.size() == 0;
            so = e && w && isfull && !p;
            su = e && p && isempty;
            if (e) begin
                if (p && !isempty) void'(mq.pop_front());
                if (w && (!isfull || p)) mq.push_back(dv);
            end
`ifdef RL_QUEUE_LVL_ERR_EN
            if (ec) begin
                m_ovf = 0;
                m_unf = 0;
            end
            if (so) m_ovf = 1;
            if (su) m_unf = 1;
`else
            so = 0;
            su = 0;
`endif
        end
    endtask

    task automatic cyc(input string tag, input bit r, c, e, w, p,
                       input logic [7:0] dv, input bit ec);
        rst = r; clr = c; ena = e; we = w; re = p; d = dv; eclr = ec;
        @(posedge clk);
        model(r, c, e, w, p, dv, ec);
        #1;
        check(tag);
    endtask

    initial begin
        rst = 1; clr = 0; ena = 0; we = 0; re = 0; d = 0; eclr = 0;
        cyc("reset", 1, 0, 0, 0, 0, 8'h00, 0);
        cyc("idle", 0, 0, 1, 0, 0, 8'h00, 0);

        cyc("push11", 0, 0, 1, 1, 0, 8'h11, 0);
        cyc("push22", 0, 0, 1, 1, 0, 8'h22, 0);
        cyc("push33", 0, 0, 1, 1, 0, 8'h33, 0);
        cyc("push44", 0, 0, 1, 1, 0, 8'h44, 0);
        cyc("pop1", 0, 0, 1, 0, 1, 8'h00, 0);
        cyc("pop2", 0, 0, 1, 0, 1, 8'h00, 0);
        cyc("pop3", 0, 0, 1, 0, 1, 8'h00, 0);
        cyc("pop4", 0, 0, 1, 0, 1, 8'h00, 0);

        for (int i = 1; i <= 4; i++)
            cyc("refill", 0, 0, 1, 1, 0, 8'(i * 8'h11), 0);
        cyc("fullpp", 0, 0, 1, 1, 1, 8'h55, 0);
        cyc("ovfpush", 0, 0, 1, 1, 0, 8'h66, 0);
        for (int i = 0; i < 4; i++)
            cyc("drain", 0, 0, 1, 0, 1, 8'h00, 0);
        cyc("unfpop", 0, 0, 1, 0, 1, 8'h00, 0);
        cyc("errclr", 0, 0, 0, 0, 0, 8'h00, 1);

        cyc("emptypp", 0, 0, 1, 1, 1, 8'h77, 0);
        cyc("errclr2", 0, 0, 1, 0, 0, 8'h00, 1);
        cyc("setwin", 0, 0, 1, 1, 1, 8'h78, 1);
        cyc("ena0", 0, 0, 0, 1, 0, 8'h99, 0);
        cyc("push3", 0, 0, 1, 1, 0, 8'h9a, 0);
        cyc("clrwe", 0, 1, 1, 1, 0, 8'hab, 0);

        cyc("p1", 0, 0, 1, 1, 0, 8'hc1, 0);
        cyc("p2", 0, 0, 1, 1, 0, 8'hc2, 0);
        cyc("rstmid", 1, 0, 1, 1, 0, 8'hc3, 0);

        for (int i = 0; i < 600; i++) begin
            cyc("rand",
                $urandom_range(99) == 0,
                $urandom_range(59) == 0,
                $urandom_range(7) != 0,
                $urandom_range(1) == 1,
                $urandom_range(2) == 0,
                8'($urandom),
                $urandom_range(9) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
